sobel_edge: RTL and testbench
=============================

SOBEL_EDGE -- requirements
Module: sobel_edge

Interface
REQ-001 Parameter: IMG_W, 640, pixels per line; legal range 4..2048.
REQ-002 Parameter: IMG_H, 480, lines per frame; legal range 4..2048.
REQ-003 clk  input  1  clock, rising-edge active.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 din  input  8  smoothed gray pixel from the upstream 3x3 Gaussian stage.
REQ-006 din_vld  input  1  din valid; gaps (din_vld=0) allowed on any cycle.
REQ-007 din_sop  input  1  first pixel of frame; qualified by din_vld.
REQ-008 din_eop  input  1  last pixel of frame; qualified by din_vld.
REQ-009 thresh  input  11  edge threshold; sampled in pipeline stage 3.
REQ-010 mag  output  8  gradient magnitude, saturated to 255.
REQ-011 dout  output  8  binary edge: 8'hFF edge, 8'h00 no edge.
REQ-012 dout_vld  output  1  mag/dout valid.
REQ-013 dout_sop  output  1  first output pixel of frame.
REQ-014 dout_eop  output  1  last output pixel of frame.

Function
REQ-015 Position counters col (0..IMG_W-1) and row (0..IMG_H-1) SHALL advance only on din_vld=1: col wraps to 0 at IMG_W-1 and row increments; row saturates at IMG_H-1.
REQ-016 A valid pixel with din_sop=1 SHALL be treated as col=0,row=0, regardless of counter state (mid-frame sop restarts the frame).
REQ-017 After a valid pixel with din_eop=1, counters SHALL return to col=0,row=0.
REQ-018 Two internal line buffers LB0 and LB1 (IMG_W x 8 each) SHALL hold the previous and second-previous lines; on a valid pixel at col c: new window column = {LB1[c], LB0[c], din} (top, mid, bottom), then LB1[c]<=LB0[c], LB0[c]<=din.
REQ-019 3x3 window p11..p33 (row 1 = top, column 1 = oldest) SHALL shift left by one column only on din_vld=1; line buffers are not cleared on sop.
REQ-020 Gx = (p13+2*p23+p33) - (p11+2*p21+p31); Gy = (p31+2*p32+p33) - (p11+2*p12+p13); both signed 11-bit, no overflow.
REQ-021 Magnitude S = |Gx| + |Gy|, unsigned 11-bit (max 2040); mag = min(S,255); dout = 8'hFF when S >= thresh, else 8'h00.
REQ-022 Border: when the window's bottom-right pixel has row<2 or col<2, mag and dout SHALL be 8'h00 regardless of window contents.
REQ-023 Output k SHALL correspond to the window whose bottom-right is input pixel k (centre at row-1, col-1); one output per valid input, in order.
REQ-024 Pipeline: stage 1 window register (on input edge n), stage 2 |Gx|,|Gy| and border flag (edge n+1), stage 3 S, threshold, outputs (edge n+2); stages 2-3 advance every clock irrespective of din_vld.
REQ-025 dout_vld/dout_sop/dout_eop SHALL equal din_vld, din_vld&din_sop, din_vld&din_eop delayed by exactly 3 clock edges (latency 3, throughput 1 pixel/clk).
REQ-026 Single-pixel frame (sop and eop on same valid pixel) SHALL produce one output with dout_sop=dout_eop=1, mag=dout=0.
REQ-027 When dout_vld=0, mag and dout SHALL hold their previous values.

Reset
REQ-028 rst_n=0 SHALL immediately clear mag, dout, dout_vld, dout_sop, dout_eop, all pipeline registers, window, col and row to 0.
REQ-029 Line buffer contents need not be reset; border zeroing (REQ-022) masks stale data.
REQ-030 Reset asserted mid-frame SHALL drop all in-flight pixels; no dout_vld until 3 edges after the first valid input following release.

Verification
REQ-031 IMG_W=8, IMG_H=8, uniform frame of 100, thresh=1, continuous vld -> 64 outputs, all mag=0, dout=0; dout_sop on output 0, dout_eop on output 63, each 3 edges after input.
REQ-032 Vertical step (cols 0-3 = 0, cols 4-7 = 200), thresh=400 -> rows>=2: col 4 and col 5 mag=255, S=800, dout=FF; other cols 0; rows 0-1 all 0.
REQ-033 Same image with din_vld toggling 1/0 every cycle -> identical output sequence to REQ-032, each output exactly 3 edges after its input.
REQ-034 Second din_sop injected at pixel 20 of frame -> counters restart; next two output lines all 0 (border), edges resume on third line.
REQ-035 rst_n pulsed low during pixel 30 -> outputs 0 immediately; restarted frame after release matches REQ-032 exactly.
REQ-036 Single valid pixel with sop=eop=1 -> one output, dout_sop=dout_eop=dout_vld=1, mag=0, dout=0.

Source files
------------

// File: rtl/sobel_edge.sv
// sobel_edge: 3x3 Sobel edge detector on a raster pixel stream.
//   Two line buffers and a 3x3 window build the neighbourhood. The next
//   stage forms |Gx| and |Gy|, and the last stage forms S = |Gx| + |Gy|,
//   saturates it into mag and compares it against thresh to give dout.
//   Latency is 3 clock edges and throughput is one pixel per clock.
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   din, din_vld                input pixel and its qualifier (gaps allowed)
//   din_sop, din_eop            first / last pixel of frame (qualified by din_vld)
//   thresh                      edge threshold on S, sampled in the last stage
//   mag, dout                   saturated magnitude / binary edge (FF or 00)
//   dout_vld, dout_sop, dout_eop  output qualifiers, delayed copies of the inputs
module sobel_edge #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  din,
    input  logic        din_vld,
    input  logic        din_sop,
    input  logic        din_eop,
    input  logic [10:0] thresh,
    output logic [7:0]  mag,
    output logic [7:0]  dout,
    output logic        dout_vld,
    output logic        dout_sop,
    output logic        dout_eop
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

    // Position counters.
    logic [CW-1:0] col_q, col_d, eff_col;
    logic [RW-1:0] row_q, row_d, eff_row;

    // Line buffers: lb0 holds the previous line, lb1 the line before it.
    logic [7:0] lb0_mem [IMG_W];
    logic [7:0] lb1_mem [IMG_W];
    logic [7:0] lb_top, lb_mid;

    // Window indexed [row][col]: row 0 = top, col 0 = oldest column.
    logic [2:0][2:0][7:0] win_q, win_d;
    logic vld1_q, vld1_d, sop1_q, sop1_d, eop1_q, eop1_d, bord1_q, bord1_d;

    // Stage 2: absolute gradients.
    logic [9:0] gx_pos, gx_neg, gy_pos, gy_neg;
    logic [9:0] ax2_q, ax2_d, ay2_q, ay2_d;
    logic vld2_q, sop2_q, eop2_q, bord2_q;

    // Stage 3: outputs.
    logic [10:0] s3;
    logic [7:0]  mag_q, mag_d, dout_q, dout_d;
    logic        vld3_q, sop3_q, eop3_q;

    // A valid sop forces the pixel to position (0,0) whatever the counters say.
    always_comb begin
        eff_col = din_sop ? '0 : col_q;
        eff_row = din_sop ? '0 : row_q;
        col_d   = col_q;
        row_d   = row_q;
        if (din_vld) begin
            if (din_eop) begin
                col_d = '0;
                row_d = '0;
            end else if (eff_col == COL_MAX) begin
                col_d = '0;
                row_d = (eff_row == ROW_MAX) ? eff_row : eff_row + RW'(1);
            end else begin
                col_d = eff_col + CW'(1);
                row_d = eff_row;
            end
        end
    end

    assign lb_top = lb1_mem[eff_col];
    assign lb_mid = lb0_mem[eff_col];

    // Line buffers are deliberately left unreset; the border flag masks stale data.
    always_ff @(posedge clk) begin
        if (din_vld) begin
            lb1_mem[eff_col] <= lb0_mem[eff_col];
            lb0_mem[eff_col] <= din;
        end
    end

    always_comb begin
        win_d   = win_q;
        bord1_d = bord1_q;
        if (din_vld) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = lb_top;
            win_d[1][2] = lb_mid;
            win_d[2][2] = din;
            bord1_d     = (eff_row < RW'(2)) || (eff_col < CW'(2));
        end
        vld1_d = din_vld;
        sop1_d = din_vld & din_sop;
        eop1_d = din_vld & din_eop;
    end

    // Positive and negative tap sums stay unsigned; |G| is taken by ordering them.
    always_comb begin
        gx_pos = {2'b00, win_q[0][2]} + {1'b0, win_q[1][2], 1'b0} + {2'b00, win_q[2][2]};
        gx_neg = {2'b00, win_q[0][0]} + {1'b0, win_q[1][0], 1'b0} + {2'b00, win_q[2][0]};
        gy_pos = {2'b00, win_q[2][0]} + {1'b0, win_q[2][1], 1'b0} + {2'b00, win_q[2][2]};
        gy_neg = {2'b00, win_q[0][0]} + {1'b0, win_q[0][1], 1'b0} + {2'b00, win_q[0][2]};
        ax2_d  = (gx_pos >= gx_neg) ? gx_pos - gx_neg : gx_neg - gx_pos;
        ay2_d  = (gy_pos >= gy_neg) ? gy_pos - gy_neg : gy_neg - gy_pos;
    end

    always_comb begin
        s3     = {1'b0, ax2_q} + {1'b0, ay2_q};
        mag_d  = mag_q;
        dout_d = dout_q;
        if (vld2_q) begin
            if (bord2_q) begin
                mag_d  = 8'h00;
                dout_d = 8'h00;
            end else begin
                mag_d  = (s3 > 11'd255) ? 8'hFF : s3[7:0];
                dout_d = (s3 >= thresh) ? 8'hFF : 8'h00;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q   <= '0;
            row_q   <= '0;
            win_q   <= '0;
            vld1_q  <= 1'b0;
            sop1_q  <= 1'b0;
            eop1_q  <= 1'b0;
            bord1_q <= 1'b0;
            ax2_q   <= '0;
            ay2_q   <= '0;
            vld2_q  <= 1'b0;
            sop2_q  <= 1'b0;
            eop2_q  <= 1'b0;
            bord2_q <= 1'b0;
            mag_q   <= '0;
            dout_q  <= '0;
            vld3_q  <= 1'b0;
            sop3_q  <= 1'b0;
            eop3_q  <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            win_q   <= win_d;
            vld1_q  <= vld1_d;
            sop1_q  <= sop1_d;
            eop1_q  <= eop1_d;
            bord1_q <= bord1_d;
            ax2_q   <= ax2_d;
            ay2_q   <= ay2_d;
            vld2_q  <= vld1_q;
            sop2_q  <= sop1_q;
            eop2_q  <= eop1_q;
            bord2_q <= bord1_q;
            mag_q   <= mag_d;
            dout_q  <= dout_d;
            vld3_q  <= vld2_q;
            sop3_q  <= sop2_q;
            eop3_q  <= eop2_q;
        end
    end

    assign mag      = mag_q;
    assign dout     = dout_q;
    assign dout_vld = vld3_q;
    assign dout_sop = sop3_q;
    assign dout_eop = eop3_q;

endmodule

// File: tb/tb_sobel_edge.sv
// tb_sobel_edge: directed frames on an 8x8 sobel_edge. Expected outputs are
// pushed into a queue as pixels are driven; a negedge monitor pops and
// compares each output, including its latency in clock edges.
module tb_sobel_edge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  din;
    logic        din_vld, din_sop, din_eop;
    logic [10:0] thresh;
    logic [7:0]  mag, dout;
    logic        dout_vld, dout_sop, dout_eop;

    sobel_edge #(.IMG_W(8), .IMG_H(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .din_vld  (din_vld),
        .din_sop  (din_sop),
        .din_eop  (din_eop),
        .thresh   (thresh),
        .mag      (mag),
        .dout     (dout),
        .dout_vld (dout_vld),
        .dout_sop (dout_sop),
        .dout_eop (dout_eop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] mag;
        logic [7:0] dout;
        logic       sop;
        logic       eop;
        int         t;
    } exp_t;

    exp_t       sb_q[$];
    int         cyc = 0;
    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] last_mag = 8'h00;
    logic [7:0] last_dout = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp_v);
        n_vec++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Monitor: pops one expectation per valid output; idle cycles must hold.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (dout_vld) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("mag", int'(mag), int'(e.mag));
                    chk("dout", int'(dout), int'(e.dout));
                    chk("dout_sop", int'(dout_sop), int'(e.sop));
                    chk("dout_eop", int'(dout_eop), int'(e.eop));
                    chk("latency", cyc - e.t, 3);
                    last_mag  = e.mag;
                    last_dout = e.dout;
                end
            end else begin
                chk("idle_hold", int'({mag, dout, dout_sop, dout_eop}),
                    int'({last_mag, last_dout, 2'b00}));
            end
        end
    end

    // kind 0: uniform h; kind 1: cols 4..7 = h else 0; kind 2: rows 4..7 = h else 0
    function automatic logic [7:0] pix(input int kind, input int h, input int r, input int c);
        if (kind == 1) return (c >= 4) ? 8'(h) : 8'h00;
        if (kind == 2) return (r >= 4) ? 8'(h) : 8'h00;
        return 8'(h);
    endfunction

    // Hand-derived S: a step of height h seen across a 3-wide window gives 4h
    // when the window straddles it (bottom-right at index 4 or 5), else 0.
    function automatic int exp_s(input int kind, input int h, input int r, input int c);
        if (kind == 1) return (c == 4 || c == 5) ? 4 * h : 0;
        if (kind == 2) return (r == 4 || r == 5) ? 4 * h : 0;
        return 0;
    endfunction

    task automatic drive_pix(input logic [7:0] d, input logic s, input logic e,
                             input logic [7:0] em, input logic [7:0] ed);
        exp_t x;
        @(posedge clk); #1;
        din = d; din_vld = 1'b1; din_sop = s; din_eop = e;
        x.mag = em; x.dout = ed; x.sop = s; x.eop = e; x.t = cyc;
        sb_q.push_back(x);
    endtask

    // Gap cycle with sop/eop raised to confirm they are ignored without vld.
    task automatic drive_gap();
        @(posedge clk); #1;
        din = 8'hAA; din_vld = 1'b0; din_sop = 1'b1; din_eop = 1'b1;
    endtask

    task automatic drive_idle();
        @(posedge clk); #1;
        din_vld = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 20 && sb_q.size() != 0; k++) @(posedge clk);
        chk("drain_timeout", sb_q.size(), 0);
        sb_q.delete();
    endtask

    // Drives pixels 0..stop_at-1 of an 8x8 frame; a full frame ends with eop and idle.
    task automatic run_frame(input int kind, input int h, input int th, input bit gaps,
                             input int stop_at, input bit use_sop);
        int r, c, s;
        logic [7:0] em, ed;
        thresh = 11'(th);
        for (int i = 0; i < 64; i++) begin
            if (i == stop_at) return;
            r = i / 8;
            c = i % 8;
            s = exp_s(kind, h, r, c);
            if (r < 2 || c < 2) begin
                em = 8'h00;
                ed = 8'h00;
            end else begin
                em = (s > 255) ? 8'hFF : 8'(s);
                ed = (s >= th) ? 8'hFF : 8'h00;
            end
            drive_pix(pix(kind, h, r, c), use_sop && (i == 0), i == 63, em, ed);
            if (gaps) drive_gap();
        end
        drive_idle();
    endtask

    initial begin
        rst_n = 1'b0; din = 8'h00; din_vld = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
        thresh = 11'd0;
        #12;
        chk("rst_mag", int'(mag), 0);
        chk("rst_dout", int'(dout), 0);
        chk("rst_flags", int'({dout_vld, dout_sop, dout_eop}), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        run_frame(0, 100, 1, 1'b0, 64, 1'b1);   // uniform frame, all zero
        wait_drain();
        run_frame(1, 200, 400, 1'b0, 64, 1'b1); // vertical step, saturated
        wait_drain();
        run_frame(1, 200, 400, 1'b1, 64, 1'b1); // same with vld toggling
        wait_drain();
        run_frame(2, 30, 120, 1'b0, 64, 1'b1);  // horizontal step, S == thresh
        wait_drain();
        run_frame(1, 50, 201, 1'b0, 64, 1'b1);  // S = 200, one below thresh
        wait_drain();
        run_frame(1, 200, 400, 1'b0, 64, 1'b0); // no sop: eop alone rewinds counters
        wait_drain();

        run_frame(1, 200, 400, 1'b0, 20, 1'b1); // sop injected at pixel 20
        run_frame(1, 200, 400, 1'b0, 64, 1'b1);
        wait_drain();

        run_frame(1, 200, 400, 1'b0, 30, 1'b1); // reset during pixel 30
        @(posedge clk); #1;
        din = pix(1, 200, 3, 6); din_vld = 1'b1; din_sop = 1'b0; din_eop = 1'b0;
        #1 rst_n = 1'b0;
        sb_q.delete();
        last_mag = 8'h00; last_dout = 8'h00;
        #1;
        chk("mid_rst_mag", int'(mag), 0);
        chk("mid_rst_dout", int'(dout), 0);
        chk("mid_rst_flags", int'({dout_vld, dout_sop, dout_eop}), 0);
        din_vld = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        run_frame(1, 200, 400, 1'b0, 64, 1'b1);
        wait_drain();

        thresh = 11'd0;
        drive_pix(8'h55, 1'b1, 1'b1, 8'h00, 8'h00); // single-pixel frame
        drive_idle();
        wait_drain();
        repeat (4) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
